prll_bs_trmnl_fifo: RTL
=======================

PRLL_BS_TRMNL_FIFO -- requirements
Module: prll_bs_trmnl_fifo

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- BITS, 32, message width; SHALL be >= 32.
- DEPTH, 16, FIFO entries; SHALL be a power of two >= 2.
- ID, 0, 8-bit source number of this terminal.
- BROADCAST, 8'hFF, target value addressing all terminals.

REQ-002 Ports SHALL be as follows, one per line.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  client write request.
- wr_data  in  BITS  client message; [BITS-1:BITS-8] target, rest payload.
- full  out  1  FIFO holds DEPTH entries.
- pop  in  1  bus arbiter consumes head entry.
- pndng  out  1  FIFO non-empty; head valid on D_pop.
- D_pop  out  BITS  head message to bus.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky: a write was dropped on full.
- err_self  out  1  sticky: a write targeted own ID.

Function
REQ-003 Block SHALL be the upstream source of one bus terminal, supplying pndng/pop/D_pop to the parallel bus arbiter.
REQ-004 An accepted write SHALL store {wr_data[BITS-1:BITS-8], ID[7:0], seq[15:0], wr_data[BITS-33:0]}.
- Client bits [BITS-9:BITS-32] SHALL be overwritten.
REQ-005 seq SHALL be a 16-bit counter, 0 after reset, incremented by 1 per accepted write only, wrapping 16'hFFFF -> 16'h0000.
REQ-006 A write SHALL be accepted when wr_en=1, target != ID (or target == BROADCAST), and (full=0 or pop=1 in the same cycle).
REQ-007 wr_en=1 with full=1 and pop=0 SHALL drop the message, hold seq, and set ovf=1 on the next edge.
REQ-008 wr_en=1 with target==ID and ID != BROADCAST SHALL drop the message, hold seq, and set err_self=1 on the next edge.
REQ-009 ovf and err_self SHALL clear only on reset.
REQ-010 FIFO SHALL be first-word-fall-through: D_pop equals the oldest entry whenever pndng=1.
REQ-011 A write accepted at edge N SHALL raise pndng and show on D_pop after edge N (zero extra latency) when the FIFO was empty.
REQ-012 pop=1 with pndng=1 SHALL remove the head at that edge; the next entry SHALL appear on D_pop after the same edge.
REQ-013 pop=1 with pndng=0 SHALL be ignored: no pointer or count change.
REQ-014 Simultaneous accepted write and valid pop SHALL leave count unchanged and preserve order, including when full and when count==1.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 full SHALL equal (count==DEPTH); pndng SHALL equal (count!=0); both SHALL be registered-state derived, never combinational from inputs.
REQ-017 D_pop SHALL be all-zero when pndng=0.

Reset
REQ-018 reset=0 SHALL immediately, without a clock edge, force all of the following:
- pointers, count and seq to 0;
- pndng=0, full=0, ovf=0, err_self=0, D_pop=0.
REQ-019 Reset asserted mid-operation SHALL discard all stored messages; no pop SHALL be honoured while reset=0.
REQ-020 The first write after reset deassertion SHALL carry seq 0.

Verification
REQ-021 Basic path: ID=1, write target 2, pop on the next cycle.
- Expect D_pop[31:0] = 32'h0201_0000, pndng high 1 cycle, count 1 -> 0.
REQ-022 Fill/overflow (DEPTH=16): 17 writes with no pop.
- Expect full=1 after the 16th write and ovf=1 after the 17th.
- Pops return seq 0..15 in order; the 17th message is never seen.
REQ-023 Full plus simultaneous write and pop: count stays 16, ovf stays 0, and the new message gets seq 16.
REQ-024 Self/broadcast: ID=3; write target 3, then target 8'hFF.
- First write is dropped with err_self=1.
- Second is stored with seq 0.
REQ-025 Wrap: 65537 accepted writes, popping continuously.
- Message 65536 carries seq 0; no ovf.
- Pointers wrap without loss.
REQ-026 Reset mid-stream: 5 entries queued, then reset=0 asynchronously between edges.
- Expect pndng=0, count=0, D_pop=0 at once.
- The next write after release carries seq 0.

Source files
------------

// File: rtl/prll_bs_trmnl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prll_bs_trmnl_fifo
// Description : Upstream source FIFO for one terminal of a parallel bus.
//               Client writes are stamped with this terminal's source ID and
//               a 16-bit sequence number, then queued first-word-fall-through
//               for the bus arbiter (pndng / pop / D_pop).
// Ports       : clk      - single clock, rising edge
//               reset    - asynchronous, active-low
//               wr_en    - client write request
//               wr_data  - client message, [BITS-1:BITS-8] = target
//               full     - FIFO holds DEPTH entries
//               pop      - arbiter consumes head entry
//               pndng    - FIFO non-empty, head valid on D_pop
//               D_pop    - head message (zero when empty)
//               count    - current occupancy
//               ovf      - sticky, a write was dropped on full
//               err_self - sticky, a write targeted this terminal's own ID
// Revision    : 1.0 - initial release
// ============================================================================
module prll_bs_trmnl_fifo #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  ID        = 8'd0,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BITS-1:0]          wr_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     pndng,
  output logic [BITS-1:0]          D_pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     err_self
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_seq;
  logic            r_ovf;
  logic            r_err_self;

  logic [7:0]      w_target;
  logic            w_self;
  logic            w_full;
  logic            w_pndng;
  logic            w_do_pop;
  logic            w_accept;
  logic [BITS-1:0] w_word;

  assign w_target = wr_data[BITS-1:BITS-8];
  // A broadcast ID can never be a self-target, so it is exempt.
  assign w_self   = (w_target == ID) && (ID != BROADCAST);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pndng  = (r_count != '0);
  assign w_do_pop = pop && w_pndng;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_accept = wr_en && !w_self && (!w_full || pop);

  // Client bits just below the target are replaced by {ID, seq}.
  generate
    if (BITS > 32) begin : g_payload
      assign w_word = {w_target, ID, r_seq, wr_data[BITS-33:0]};
    end else begin : g_no_payload
      assign w_word = {w_target, ID, r_seq};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_ovf      <= 1'b0;
      r_err_self <= 1'b0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_seq    <= r_seq + 16'd1;
      end
      case ({w_accept, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full && !pop) begin
        r_ovf <= 1'b1;
      end
      if (wr_en && w_self) begin
        r_err_self <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the read side is masked by pndng. When full with a
  // simultaneous pop, the write overwrites the head slot being popped, which
  // is safe because the old head is read combinationally before the edge.
  always_ff @(posedge clk) begin
    if (reset && w_accept) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  assign full     = w_full;
  assign pndng    = w_pndng;
  assign D_pop    = w_pndng ? r_mem[r_rd_ptr] : '0;
  assign count    = r_count;
  assign ovf      = r_ovf;
  assign err_self = r_err_self;

endmodule
`default_nettype wire
